// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry elastic pipeline register (main + skid).
// in_ready is registered so no combinational path runs from out_ready back
// upstream; the skid entry absorbs the one extra beat that can arrive while
// downstream stalls. Bubbles present as all-zero payload with A3 = 0 and are
// counted in a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_a3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_a3,
  output logic [CW-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic [AW-1:0] main_a3_q, main_a3_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic [AW-1:0] skid_a3_q, skid_a3_d;
  logic          in_ready_q, in_ready_d;
  logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;

  logic in_xfer;
  logic out_xfer;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    logic [CW-1:0] one;
    one = {{(CW-1){1'b0}}, 1'b1};
    return (c == {CW{1'b1}}) ? c : c + one;
  endfunction

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign in_xfer    = in_valid & in_ready_q;
  assign out_xfer   = out_valid & out_ready;
  // Gate the payload so a bubble always reads as an all-zero nop, whatever
  // the holding registers contain.
  assign out_data   = out_valid ? main_data_q : '0;
  assign out_a3     = out_valid ? main_a3_q : '0;
  assign bubble_cnt = bubble_cnt_q;

  // Next-state, entry movement, registered ready and bubble counting.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_a3_d   = main_a3_q;
    skid_data_d = skid_data_q;
    skid_a3_d   = skid_a3_q;

    if (flush) begin
      // Kill everything held, including any beat accepted this cycle.
      state_d     = EMPTY;
      main_data_d = '0;
      main_a3_d   = '0;
      skid_data_d = '0;
      skid_a3_d   = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_a3_d   = in_a3;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_data_d = in_data;
            main_a3_d   = in_a3;
          end else if (in_xfer) begin
            // Downstream stalled: park the new beat behind the main entry.
            state_d     = TWO;
            skid_data_d = in_data;
            skid_a3_d   = in_a3;
          end else if (out_xfer) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_a3_d   = '0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain can happen.
          if (out_xfer) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_a3_d   = skid_a3_q;
            skid_data_d = '0;
            skid_a3_d   = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = '0;
          main_a3_d   = '0;
          skid_data_d = '0;
          skid_a3_d   = '0;
        end
      endcase
    end

    // Ready for next cycle is a function of the next occupancy only.
    in_ready_d   = (state_d != TWO);
    bubble_cnt_d = (state_q == EMPTY) ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
  end

  // State and holding registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_a3_q    <= '0;
      skid_data_q  <= '0;
      skid_a3_q    <= '0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_a3_q    <= main_a3_d;
      skid_data_q  <= skid_data_d;
      skid_a3_q    <= skid_a3_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DW, default 32, payload width in bits (instr/PC/result/data fields packed by the instantiating stage).
REQ-002 SHALL provide parameter AW, default 5, destination register address width.
REQ-003 SHALL provide parameter CW, default 16, bubble-counter width.
REQ-004 Port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: flush  input  1  discard all held entries (branch/exception kill).
REQ-007 Port: in_valid  input  1  upstream stage presents an entry.
REQ-008 Port: in_ready  output  1  this stage can accept an entry this cycle.
REQ-009 Port: in_data  input  DW  upstream payload.
REQ-010 Port: in_a3  input  AW  upstream destination register.
REQ-011 Port: out_valid  output  1  entry presented downstream.
REQ-012 Port: out_ready  input  1  downstream accepts the presented entry.
REQ-013 Port: out_data  output  DW  presented payload.
REQ-014 Port: out_a3  output  AW  presented destination register; 0 whenever out_valid=0.
REQ-015 Port: bubble_cnt  output  CW  count of cycles with out_valid=0 since reset.

Function
REQ-016 SHALL hold up to two entries: main register (drives outputs) and skid register; occupancy state EMPTY, ONE, TWO.
REQ-017 in_ready SHALL be a registered signal equal to (state != TWO); no combinational path from out_ready to in_ready.
REQ-018 Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-019 out_valid SHALL be 1 exactly when state is ONE or TWO.
REQ-020 EMPTY: input transfer -> entry into main, state ONE, visible on outputs next cycle (latency 1).
REQ-021 ONE, input and output transfer same cycle -> new entry into main, state stays ONE.
REQ-022 ONE, input only -> new entry into skid, state TWO, main unchanged.
REQ-023 ONE, output only -> state EMPTY.
REQ-024 TWO, output transfer -> skid moves to main, state ONE; no input transfer possible (in_ready=0).
REQ-025 Entries SHALL leave in arrival order; no entry SHALL be duplicated or dropped except by flush/reset.
REQ-026 flush=1 SHALL, next cycle, force state EMPTY, out_valid=0, out_data=0, out_a3=0, in_ready=1; a simultaneous input transfer SHALL be discarded.
REQ-027 When out_valid=0, out_data and out_a3 SHALL read 0 (bubble is all-zero, i.e. nop with A3=0).
REQ-028 bubble_cnt SHALL increment by 1 each cycle out_valid=0 (including flush-induced bubbles), saturating at 2^CW-1; never wraps.
REQ-029 Skid contents SHALL not affect outputs while state is ONE or EMPTY.

Reset
REQ-030 reset=1 at posedge clk SHALL set state EMPTY, out_valid=0, out_data=0, out_a3=0, in_ready=1, bubble_cnt=0, skid register=0.
REQ-031 reset SHALL take priority over flush, in_valid and out_ready; reset mid-operation with state TWO SHALL discard both entries.
REQ-032 The first cycle after reset deasserts SHALL count as a bubble if out_valid=0.

Verification
REQ-033 Streaming: out_ready=1, in_valid=1 for 4 cycles with in_data=1,2,3,4, in_a3=8 -> out_data 1,2,3,4 on consecutive cycles, each one cycle after input, out_a3=8, in_ready stays 1.
REQ-034 Backpressure: state ONE holding 0xA, out_ready=0, input 0xB -> state TWO, in_ready=0 next cycle; out_ready=1 -> 0xA then 0xB delivered, in_ready returns to 1 after 0xA leaves.
REQ-035 Flush: state TWO (0xA,0xB), flush=1 with in_valid=1 in_data=0xC -> next cycle out_valid=0, out_data=0, out_a3=0, in_ready=1; 0xC never appears.
REQ-036 Reset mid-operation: state TWO, reset=1 one cycle -> all outputs 0, in_ready=1, bubble_cnt=0; subsequent input 0x5 emerges normally.
REQ-037 Saturation: CW=3, in_valid=0 for 10 cycles after reset -> bubble_cnt reads 1..7 then holds 7.
